// File: rtl/booth_seq_pkg.sv
// Shared types and sizing helpers for the sequential Booth multiplier.
// Defining BOOTH_RADIX4_EN selects radix-4 modified Booth recoding; otherwise radix-2.
package booth_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } boothState_e;

  localparam int unsigned DefaultWidth = 25;

`ifdef BOOTH_RADIX4_EN
  localparam bit Radix4En = 1'b1;
`else
  localparam bit Radix4En = 1'b0;
`endif

  // Radix-4 retires two multiplier bits per step over a sign-extended (width+1)-bit multiplier.
  function automatic int unsigned iterCount(input int unsigned width, input bit radix4);
    return radix4 ? (width + 2) / 2 : width;
  endfunction

endpackage

// File: rtl/booth_recoder.sv
// Combinational Booth digit decoder: maps a 3-bit multiplier window {b+1, b, b-1}
// to a signed digit in {0, +-1, +-2} expressed as zero/negate/double selects.
module booth_recoder (
  input  logic [2:0] window,
  output logic       selZero,
  output logic       selNeg,
  output logic       selDouble
);

  always_comb begin
    selZero   = (window == 3'b000) || (window == 3'b111);
    selDouble = (window == 3'b011) || (window == 3'b100);
    selNeg    = window[2];
  end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential signed Booth multiplier, one recoded digit per cycle.
// BOOTH_RADIX4_EN selects radix-4 (ceil((WIDTH+1)/2) steps) instead of radix-2 (WIDTH steps).
module booth_seq_multiplier
  import booth_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     M,
  input  logic [WIDTH-1:0]     Q,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   Z
);

  localparam int unsigned N     = iterCount(WIDTH, Radix4En);
  localparam int unsigned Shift = Radix4En ? 2 : 1;
  // One guard bit per shifted position keeps +-2M and -(most negative M) exact.
  localparam int unsigned AccW  = WIDTH + Shift;
  localparam int unsigned QW    = Radix4En ? 2 * N : WIDTH;
  localparam int unsigned TotW  = AccW + QW + 1;
  localparam int unsigned CntW  = $clog2(N + 1);
  localparam int unsigned ZW    = 2 * WIDTH;

  boothState_e stateQ, stateD;
  logic [WIDTH-1:0] mQ, mD;
  logic [AccW-1:0]  accQ, accD;
  logic [QW-1:0]    mulQ, mulD;
  logic             qm1Q, qm1D;
  logic [CntW-1:0]  cntQ, cntD;
  logic [ZW-1:0]    zQ, zD;

  logic [2:0] window;
  logic       selZero, selNeg, selDouble;

`ifdef BOOTH_RADIX4_EN
  assign window = {mulQ[1], mulQ[0], qm1Q};
`else
  // Duplicating bit 0 makes the radix-4 table yield the radix-2 digits {0, +1, -1}.
  assign window = {mulQ[0], mulQ[0], qm1Q};
`endif

  booth_recoder u_recoder (
    .window   (window),
    .selZero  (selZero),
    .selNeg   (selNeg),
    .selDouble(selDouble)
  );

  logic signed [AccW-1:0] mExt, mag, pp, sum;
  logic signed [TotW-1:0] shifted;

  always_comb begin
    mExt    = AccW'($signed(mQ));
    mag     = selDouble ? (mExt <<< 1) : mExt;
    pp      = selZero ? '0 : (selNeg ? -mag : mag);
    sum     = $signed(accQ) + pp;
    shifted = $signed({sum, mulQ, qm1Q}) >>> Shift;
  end

  always_comb begin
    stateD = stateQ;
    mD     = mQ;
    accD   = accQ;
    mulD   = mulQ;
    qm1D   = qm1Q;
    cntD   = cntQ;
    zD     = zQ;
    unique case (stateQ)
      StIdle: begin
        if (start) begin
          mD     = M;
          accD   = '0;
          mulD   = QW'($signed(Q));
          qm1D   = 1'b0;
          cntD   = CntW'(N);
          stateD = StRun;
        end
      end
      StRun: begin
        if (cntQ == '0) begin
          zD     = ZW'({accQ, mulQ});
          stateD = StDone;
        end else begin
          accD = shifted[TotW-1 -: AccW];
          mulD = shifted[QW:1];
          qm1D = shifted[0];
          cntD = cntQ - CntW'(1);
        end
      end
      StDone: stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= StIdle;
      mQ     <= '0;
      accQ   <= '0;
      mulQ   <= '0;
      qm1Q   <= 1'b0;
      cntQ   <= '0;
      zQ     <= '0;
    end else begin
      stateQ <= stateD;
      mQ     <= mD;
      accQ   <= accD;
      mulQ   <= mulD;
      qm1Q   <= qm1D;
      cntQ   <= cntD;
      zQ     <= zD;
    end
  end

  assign busy = (stateQ != StIdle);
  assign done = (stateQ == StDone);
  assign Z    = zQ;

endmodule

// File: doc/booth_seq_multiplier.md
BOOTH_SEQ_MULTIPLIER -- requirements
Module: booth_seq_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 25, giving the operand width in bits (two's-complement, matches the {1'b0, mantissa} operand format).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset: synchronous, active-high.
REQ-004 The block SHALL have port start, input, 1, the request to capture M and Q and begin a multiply.
REQ-005 The block SHALL have port M, input, WIDTH, the multiplicand (signed).
REQ-006 The block SHALL have port Q, input, WIDTH, the multiplier (signed).
REQ-007 The block SHALL have port busy, output, 1, high while a multiply is in progress.
REQ-008 The block SHALL have port done, output, 1, a one-cycle pulse marking Z as newly valid.
REQ-009 The block SHALL have port Z, output, 2*WIDTH, the signed product, registered and held.

Function
REQ-010 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-011 In IDLE with start=1, the block SHALL register M and Q, clear the accumulator, load the iteration counter with N, and enter RUN.
REQ-012 In RUN, the block SHALL perform one Booth iteration per cycle: add, subtract or skip M per the recoded multiplier bits, then arithmetic-shift {acc, Q, q-1} right; it SHALL decrement the counter.
REQ-013 When the counter reaches 0, the block SHALL leave RUN for DONE and load Z with the full 2*WIDTH signed product on the same edge.
REQ-014 DONE SHALL last exactly one cycle, with done=1, and then return to IDLE.
REQ-015 Latency: done SHALL be high in the cycle following the (N+1)th rising edge after the edge that sampled start.
REQ-016 Radix-2 operation SHALL use N = WIDTH.
REQ-017 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-018 start while busy=1 SHALL be ignored, with no queuing and no corruption of the operation in flight.
REQ-019 Back-to-back operation: start asserted in the cycle after done SHALL be accepted; Z SHALL hold its old value until the new DONE.
REQ-020 Z SHALL change only on entry to DONE or on reset.
REQ-021 M and Q SHALL be sampled only at start acceptance; changes to them during RUN SHALL have no effect.
REQ-022 Arithmetic SHALL use a WIDTH+1 bit accumulator to absorb the subtract of the most-negative M without overflow; the result SHALL be exact for all operand pairs, including -2^(WIDTH-1) * -2^(WIDTH-1).

Reset
REQ-023 On rst=1 at a clock edge, the block SHALL enter IDLE and set busy=0, done=0, Z=0, counter=0 and accumulator=0.
REQ-024 rst SHALL take priority over start.
REQ-025 rst mid-RUN SHALL abort the operation, with no done pulse for it.
REQ-026 start SHALL be accepted on the first edge after rst deasserts.

Configuration
REQ-027 Macro BOOTH_RADIX4_EN SHALL select the recoding mode.
REQ-028 When BOOTH_RADIX4_EN is defined, the block SHALL use radix-4 modified Booth: it SHALL examine 3 bits per iteration, select 0, ±M or ±2M, shift by 2, and use N = ceil((WIDTH+1)/2) (13 for WIDTH=25) with the multiplier sign-extended to 2N bits.
REQ-029 When BOOTH_RADIX4_EN is undefined, the block SHALL use radix-2 with N = WIDTH (25 iterations).
REQ-030 The interface, handshake and Z value SHALL be identical in both modes; only latency SHALL differ.

Structure
REQ-031 Shared package booth_seq_pkg SHALL hold the FSM state enum, the default WIDTH, and the iteration-count function of WIDTH and mode.
REQ-032 One sub-module SHALL be used: booth_recoder, which is combinational and maps the multiplier LSB window to {zero, negate, double} selects; it SHALL be instantiated once.

Verification
REQ-033 The bench SHALL apply M=5, Q=3 with a 1-cycle start in radix-2 mode and check Z=0x0000000000000F, done high 26 edges after the start edge, and busy low the following cycle.
REQ-034 The bench SHALL apply M=0x1FFFFFF (-1), Q=0x0000001 and check Z=0x3FFFFFFFFFFFF.
REQ-035 The bench SHALL apply M=Q=0x0FFFFFF (max mantissa) and check Z=0x0FFFFFE000001; with BOOTH_RADIX4_EN it SHALL check the same Z with done 14 edges after start.
REQ-036 The bench SHALL apply M=Q=0x1000000 (-2^24) and check Z=0x1000000000000 (no overflow).
REQ-037 The bench SHALL pulse start=1 with M=7, Q=7 at cycle 5 of a running 2*3 multiply and check Z=6, a single done pulse, and that the 7*7 request is dropped.
REQ-038 The bench SHALL assert rst at RUN cycle 10 of 9*9 and check no done pulse, Z=0 and busy=0 the next cycle; a following 2*2 multiply SHALL give Z=4.
